// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Provides the fetch FSM state enum, the 32-bit word type and default constants.
// Ports: none (package).
package mips_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Bubble instruction: sll $0,$0,0
  localparam word_t FETCH_NOP_WORD = 32'h0000_0000;
  localparam word_t FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_adder.sv
// Combinational PC incrementer (+4, wraps modulo 2^32).
// Ports: i_pc (current PC), o_pc_plus4 (i_pc + 4).
// Latency: zero cycles; no handshake.
module pc_adder
  import mips_pkg::*;
(
  input  word_t i_pc,
  output word_t o_pc_plus4
);

  assign o_pc_plus4 = i_pc + 32'd4;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, next-PC select, single-outstanding imem handshake.
// Ports: Clk/Reset; hazard NotStall; ID redirects (BranchTaken/BranchTarget, Jump/JumpTarget);
//   imem IMemReq/IMemAddr/IMemReady/IMemData; IF/ID outputs PC_IF, PCAdderResult_IF,
//   Instruction_IF, FetchValid_IF, AddrError_IF.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect detection + forced alignment).
module instruction_fetch
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = FETCH_RESET_PC,
  parameter word_t NOP_WORD = FETCH_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        NotStall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] PC_IF,
  output logic [31:0] PCAdderResult_IF,
  output logic [31:0] Instruction_IF,
  output logic        FetchValid_IF,
  output logic        AddrError_IF
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  word_t        r_pc;
  word_t        w_pc_nxt;
  word_t        r_buffer;
  word_t        w_buffer_nxt;
  word_t        r_redirect_pc;
  word_t        w_redirect_pc_nxt;
  word_t        w_pc_plus4;
  word_t        w_target_raw;
  word_t        w_target;
  logic         w_redirect;

  pc_adder u_pc_adder (
    .i_pc       (r_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  // Branch has priority over jump when both resolve in the same cycle.
  assign w_redirect   = BranchTaken | Jump;
  assign w_target_raw = BranchTaken ? BranchTarget : JumpTarget;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_addr_error;

  assign w_target     = {w_target_raw[31:2], 2'b00};
  assign AddrError_IF = r_addr_error;

  // Sticky until reset so software-visible faults are never lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr_error <= 1'b0;
    end else if (w_redirect && (w_target_raw[1:0] != 2'b00)) begin
      r_addr_error <= 1'b1;
    end
  end
`else
  assign w_target     = w_target_raw;
  assign AddrError_IF = 1'b0;
`endif

  // The request address is the PC register itself, so it cannot move while a
  // request is pending: the PC only updates on IMemReady or from HOLD.
  assign IMemAddr         = r_pc;
  assign PC_IF            = r_pc;
  assign PCAdderResult_IF = w_pc_plus4;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_buffer_nxt      = r_buffer;
    w_redirect_pc_nxt = r_redirect_pc;
    IMemReq           = 1'b0;
    Instruction_IF    = NOP_WORD;
    FetchValid_IF     = 1'b0;

    case (r_state)
      FETCH: begin
        IMemReq = 1'b1;
        if (IMemReady && !w_redirect) begin
          Instruction_IF = IMemData;
          FetchValid_IF  = 1'b1;
        end
        if (w_redirect) begin
          if (IMemReady) begin
            w_pc_nxt = w_target;
          end else begin
            // Request still in flight: remember where to go once it drains.
            w_redirect_pc_nxt = w_target;
            w_state_nxt       = DISCARD;
          end
        end else if (IMemReady) begin
          if (NotStall) begin
            w_pc_nxt = w_pc_plus4;
          end else begin
            w_buffer_nxt = IMemData;
            w_state_nxt  = HOLD;
          end
        end
      end

      HOLD: begin
        Instruction_IF = r_buffer;
        FetchValid_IF  = 1'b1;
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = FETCH;
        end else if (NotStall) begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = FETCH;
        end
      end

      DISCARD: begin
        // Keep the old request alive until memory answers, then drop the data.
        IMemReq = 1'b1;
        if (w_redirect) begin
          w_redirect_pc_nxt = w_target;
        end
        if (IMemReady) begin
          w_pc_nxt    = w_redirect ? w_target : r_redirect_pc;
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase

    // Reset abandons any pending request immediately.
    if (Reset) begin
      IMemReq        = 1'b0;
      Instruction_IF = NOP_WORD;
      FetchValid_IF  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_buffer      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_buffer      <= w_buffer_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        Clk;
  logic        Reset;
  logic        NotStall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] PC_IF;
  logic [31:0] PCAdderResult_IF;
  logic [31:0] Instruction_IF;
  logic        FetchValid_IF;
  logic        AddrError_IF;

  int n_cmp;
  int n_err;

  instruction_fetch dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .NotStall         (NotStall),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .Jump             (Jump),
    .JumpTarget       (JumpTarget),
    .IMemReq          (IMemReq),
    .IMemAddr         (IMemAddr),
    .IMemReady        (IMemReady),
    .IMemData         (IMemData),
    .PC_IF            (PC_IF),
    .PCAdderResult_IF (PCAdderResult_IF),
    .Instruction_IF   (Instruction_IF),
    .FetchValid_IF    (FetchValid_IF),
    .AddrError_IF     (AddrError_IF)
  );

  // Memory contents: 0x1000_0000 + address, except a load word at address 8.
  assign IMemData = (IMemAddr == 32'h8) ? 32'h8C01_0004 : (32'h1000_0000 + IMemAddr);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_align_addr;
    logic        exp_align_err;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_align_addr = 32'h100;
    exp_align_err  = 1'b1;
`else
    exp_align_addr = 32'h102;
    exp_align_err  = 1'b0;
`endif
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1;
    NotStall = 1'b1;
    BranchTaken = 1'b0;
    BranchTarget = 32'h0;
    Jump = 1'b0;
    JumpTarget = 32'h0;
    IMemReady = 1'b1;

    // Reset cycle
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req",   IMemReq, 0);
    chk("rst_valid", FetchValid_IF, 0);
    chk("rst_instr", Instruction_IF, 32'h0);
    chk("rst_pc",    PC_IF, 32'h0);
    chk("rst_aerr",  AddrError_IF, 0);

    // Zero-wait stream
    Reset = 1'b0;
    #1;
    chk("s0_req",   IMemReq, 1);
    chk("s0_addr",  IMemAddr, 32'h0);
    chk("s0_valid", FetchValid_IF, 1);
    chk("s0_instr", Instruction_IF, 32'h1000_0000);
    chk("s0_pc4",   PCAdderResult_IF, 32'h4);
    cyc();
    chk("s1_pc",    PC_IF, 32'h4);
    chk("s1_instr", Instruction_IF, 32'h1000_0004);
    chk("s1_valid", FetchValid_IF, 1);

    // Stall three cycles while the word at 8 returns
    cyc();
    NotStall = 1'b0;
    #1;
    chk("st0_pc",    PC_IF, 32'h8);
    chk("st0_instr", Instruction_IF, 32'h8C01_0004);
    chk("st0_valid", FetchValid_IF, 1);
    cyc();
    chk("st1_req",   IMemReq, 0);
    chk("st1_instr", Instruction_IF, 32'h8C01_0004);
    chk("st1_pc",    PC_IF, 32'h8);
    chk("st1_valid", FetchValid_IF, 1);
    cyc();
    chk("st2_req",   IMemReq, 0);
    chk("st2_pc",    PC_IF, 32'h8);
    NotStall = 1'b1;
    #1;
    chk("st3_instr", Instruction_IF, 32'h8C01_0004);
    cyc();
    chk("rel_addr",  IMemAddr, 32'hC);
    chk("rel_req",   IMemReq, 1);

    // Two-cycle memory, branch during the wait at 0x10
    cyc();
    IMemReady = 1'b0;
    BranchTaken = 1'b1;
    BranchTarget = 32'h40;
    #1;
    chk("bw_addr",  IMemAddr, 32'h10);
    chk("bw_valid", FetchValid_IF, 0);
    chk("bw_instr", Instruction_IF, 32'h0);
    cyc();
    BranchTaken = 1'b0;
    BranchTarget = 32'h0;
    #1;
    chk("dis0_addr",  IMemAddr, 32'h10);
    chk("dis0_req",   IMemReq, 1);
    chk("dis0_valid", FetchValid_IF, 0);
    cyc();
    IMemReady = 1'b1;
    #1;
    chk("dis1_addr",  IMemAddr, 32'h10);
    chk("dis1_valid", FetchValid_IF, 0);
    chk("dis1_instr", Instruction_IF, 32'h0);
    cyc();
    chk("br_addr",  IMemAddr, 32'h40);
    chk("br_valid", FetchValid_IF, 1);

    // Branch and jump together: branch wins
    BranchTaken = 1'b1;
    BranchTarget = 32'h80;
    Jump = 1'b1;
    JumpTarget = 32'h200;
    #1;
    chk("bj_valid", FetchValid_IF, 0);
    cyc();
    BranchTaken = 1'b0;
    Jump = 1'b0;
    #1;
    chk("bj_addr", IMemAddr, 32'h80);

    // Redirect while holding a buffered word
    NotStall = 1'b0;
    cyc();
    chk("hr_instr", Instruction_IF, 32'h1000_0080);
    Jump = 1'b1;
    JumpTarget = 32'h100;
    #1;
    chk("hr_req", IMemReq, 0);
    cyc();
    Jump = 1'b0;
    NotStall = 1'b1;
    #1;
    chk("hr_addr",  IMemAddr, 32'h100);
    chk("hr_instr2", Instruction_IF, 32'h1000_0100);

    // Misaligned jump target
    Jump = 1'b1;
    JumpTarget = 32'h102;
    cyc();
    Jump = 1'b0;
    #1;
    chk("al_addr", IMemAddr, exp_align_addr);
    chk("al_aerr", AddrError_IF, {31'b0, exp_align_err});
    cyc();
    chk("al_aerr2", AddrError_IF, {31'b0, exp_align_err});

    // PC+4 wrap at the top of the address space
    Jump = 1'b1;
    JumpTarget = 32'hFFFF_FFFC;
    cyc();
    Jump = 1'b0;
    #1;
    chk("wrap_pc",  PC_IF, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCAdderResult_IF, 32'h0);
    cyc();
    chk("wrap_next", PC_IF, 32'h0);

    // Reset in the middle of a memory wait
    cyc();
    IMemReady = 1'b0;
    #1;
    chk("mw_req", IMemReq, 1);
    Reset = 1'b1;
    #1;
    chk("mw_rst_req",   IMemReq, 0);
    chk("mw_rst_valid", FetchValid_IF, 0);
    cyc();
    Reset = 1'b0;
    IMemReady = 1'b1;
    #1;
    chk("post_pc",   PC_IF, 32'h0);
    chk("post_aerr", AddrError_IF, 0);
    chk("post_req",  IMemReq, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
